// File: rtl/seq_test_pkg.sv
// Shared state encoding and default sizing for the sequence self-test controller.
package seq_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RST_CYC   = 2;
  localparam int DEF_DRAIN_CYC = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment is dropped once the count is all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/seq_test_controller.sv
// Runs one generator/detector self-check: reset pulse, enable window, drain window,
// then compares the number of detector hits against the expected count.
module seq_test_controller
  import seq_test_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RST_CYC   = DEF_RST_CYC,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] bit_count,
  input  logic [CNT_W-1:0] exp_hits,
  input  logic             y,
  output logic             dut_reset,
  output logic             gen_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] bits_sent
);

  localparam int PH_W = $clog2(max_int(RST_CYC, DRAIN_CYC) + 1);

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] bit_cnt_lat;
  logic [CNT_W-1:0] exp_lat;

  logic             cnt_clear;
  logic             hit_inc;
  logic             bits_inc;
  logic             run_last;
  logic [CNT_W-1:0] hit_next;

  // Counter controls; abort freezes both counters on the cycle it is seen.
  always_comb begin
    cnt_clear = (state == IDLE) && start && !abort;
    bits_inc  = (state == RUN) && !abort;
    hit_inc   = y && !abort && ((state == RUN) || (state == DRAIN));
    run_last  = ((bits_sent + CNT_W'(1)) == bit_cnt_lat);
    if (hit_inc && (hit_count != {CNT_W{1'b1}})) begin
      hit_next = hit_count + CNT_W'(1);
    end else begin
      hit_next = hit_count;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_bits_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (bits_inc),
    .count (bits_sent)
  );

  // Run sequencer with registered outputs and the shared reset/drain phase counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= '0;
      bit_cnt_lat <= '0;
      exp_lat     <= '0;
      dut_reset   <= 1'b0;
      gen_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      phase     <= '0;
      dut_reset <= 1'b0;
      gen_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt_lat <= bit_count;
            exp_lat     <= exp_hits;
            busy        <= 1'b1;
            if (bit_count == '0) begin
              // Empty run: nothing is counted, so the verdict is known right away.
              state <= DONE;
              done  <= 1'b1;
              pass  <= (exp_hits == '0);
            end else begin
              state     <= RST;
              dut_reset <= 1'b1;
              phase     <= PH_W'(RST_CYC - 1);
              pass      <= 1'b0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RST: begin
          if (phase == '0) begin
            state     <= RUN;
            dut_reset <= 1'b0;
            gen_en    <= 1'b1;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        RUN: begin
          if (run_last) begin
            state  <= DRAIN;
            gen_en <= 1'b0;
            phase  <= PH_W'(DRAIN_CYC - 1);
          end else begin
            gen_en <= 1'b1;
          end
        end
        DRAIN: begin
          if (phase == '0) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (hit_next == exp_lat);
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          dut_reset <= 1'b0;
          gen_en    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
